layer_input_server: RTL and testbench
=====================================

Name: layer_input_server

Overview:
- Responder at the other end of a layer's input-activation read channel.
- Buffers one input vector loaded from upstream and asserts the layer's request.
- Answers the layer's trigger/address reads with one-cycle latency.
- Captures the layer's output activations when the layer acknowledges, then hands them downstream with a valid/ready handshake.
- Sits between the network's input feeder and each layer instance.

Parameters:
DATA_W, 8, signed activation width
DEPTH, 2, number of input activations per vector
ADDR_W, 1, read address width (2**ADDR_W >= DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
load_valid  in  1  upstream offers an input word
load_data  in  DATA_W  signed input word
load_ready  out  1  server accepts a word this cycle
req  out  1  request to layer; start MAC sequence
rd_trig  in  1  layer read strobe
rd_addr  in  ADDR_W  layer read address
rd_data  out  DATA_W  signed read data
rd_ack  out  1  rd_data valid this cycle
layer_ack  in  1  layer outputs valid
layer_out0  in  DATA_W  layer output activation 0
layer_out1  in  DATA_W  layer output activation 1
res_valid  out  1  captured results available
res_data0  out  DATA_W  captured activation 0
res_data1  out  DATA_W  captured activation 1
res_ready  in  1  downstream consumes results
addr_err  out  1  sticky: read with rd_addr >= DEPTH seen

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, wr_ptr=0, buffer words=0.
  - req=0, rd_ack=0, rd_data=0, res_valid=0, res_data0/1=0, addr_err=0.
  - Reset applies at any point, mid-load or mid-run; no partial results survive.
- FSM states: LOAD, RUN, HOLD.
- LOAD:
  - load_ready=1.
  - On load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr++.
  - When the word written is at wr_ptr==DEPTH-1: wr_ptr<=0 and go to RUN next cycle.
- RUN:
  - req=1 (registered; first high cycle is the cycle after entry). load_ready=0.
  - Read port: rd_trig=1 at edge t → at t+1 rd_ack=1 and rd_data=mem[rd_addr sampled at t].
  - rd_ack is a single-cycle pulse per trigger. Back-to-back triggers produce back-to-back acks, each answering its own address.
  - rd_addr >= DEPTH: rd_data=0, rd_ack=1, addr_err<=1. addr_err is cleared only by reset.
  - Reads are repeatable; the buffer is never modified in RUN.
  - layer_ack=1: capture res_data0<=layer_out0 and res_data1<=layer_out1, req<=0, res_valid<=1, go to HOLD.
  - A rd_trig in the same cycle as layer_ack is still answered at t+1.
- HOLD:
  - res_valid=1, load_ready=0, req=0.
  - rd_trig is ignored: rd_ack=0, rd_data holds its last value.
  - layer_ack pulses are ignored; captured data is stable.
  - res_ready=1: res_valid<=0, go to LOAD next cycle.
  - load_valid asserted during HOLD is not accepted. Upstream retries in LOAD.
- rd_trig outside RUN: no ack, no error.
- Latencies:
  - Last load word to req high: 1 cycle.
  - rd_trig to rd_ack: 1 cycle.
  - layer_ack to res_valid: 1 cycle.
  - res_ready to load_ready: 1 cycle.
- Arithmetic: none. Data is passed bit-exact, signed two's complement, no resizing.

Test Plan:
- Reset then load 16, -32 → load_ready high for 2 accepts. req rises the cycle after the 2nd accept. load_ready=0.
- In RUN: rd_trig with addr 0, then addr 1 on consecutive cycles → rd_ack high 2 cycles, rd_data 16 then -32 (0xE0).
- rd_trig with rd_addr=1 four times, spaced 3 cycles apart → each ack returns -32; addr_err stays 0.
- layer_ack with layer_out0=5, layer_out1=-3 in the same cycle as a rd_trig addr 0 → next cycle rd_ack=1 with rd_data=16, res_valid=1, res_data0=5, res_data1=-3 (0xFD), req=0.
- HOLD with res_ready=0 for 4 cycles while load_valid=1 and layer_ack pulses with other values → res data unchanged, no load accepted. Then res_ready=1 → LOAD; a new vector 7, 8 is read back correctly.
- rst driven low mid-RUN after one read → all outputs 0 immediately (asynchronous). After release, state is LOAD and a read of addr 0 before loading gives no rd_ack.

Source files
------------

// File: rtl/layer_input_server.sv
// rtl/layer_input_server.sv - input-activation buffer and read responder for one layer
// Loads one vector from upstream, serves the layer's reads, captures and forwards its outputs.
module layer_input_server #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_valid_i,
    input  logic signed [DATA_W-1:0] load_data_i,
    output logic                     load_ready_o,
    output logic                     req_o,
    input  logic                     rd_trig_i,
    input  logic        [ADDR_W-1:0] rd_addr_i,
    output logic signed [DATA_W-1:0] rd_data_o,
    output logic                     rd_ack_o,
    input  logic                     layer_ack_i,
    input  logic signed [DATA_W-1:0] layer_out0_i,
    input  logic signed [DATA_W-1:0] layer_out1_i,
    output logic                     res_valid_o,
    output logic signed [DATA_W-1:0] res_data0_o,
    output logic signed [DATA_W-1:0] res_data1_o,
    input  logic                     res_ready_i,
    output logic                     addr_err_o
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                     state_q;
    logic        [ADDR_W-1:0]   wr_ptr_q;
    logic signed [DATA_W-1:0]   mem_q [DEPTH];
    logic                       req_q;
    logic                       rd_ack_q;
    logic signed [DATA_W-1:0]   rd_data_q;
    logic                       res_valid_q;
    logic signed [DATA_W-1:0]   res_data0_q;
    logic signed [DATA_W-1:0]   res_data1_q;
    logic                       addr_err_q;

    logic                       addr_ok;
    logic signed [DATA_W-1:0]   rd_word_d;

    // Out-of-range reads still get an ack, but with zero data and a sticky error.
    always_comb begin
        addr_ok   = ({1'b0, rd_addr_i} < (ADDR_W+1)'(DEPTH));
        rd_word_d = '0;
        if (addr_ok) begin
            rd_word_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            req_q       <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data0_q <= '0;
            res_data1_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            rd_ack_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (load_valid_i) begin
                        mem_q[wr_ptr_q] <= load_data_i;
                        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            wr_ptr_q <= '0;
                            req_q    <= 1'b1;
                            state_q  <= RUN;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A read triggered alongside layer_ack is still answered.
                    if (rd_trig_i) begin
                        rd_ack_q  <= 1'b1;
                        rd_data_q <= rd_word_d;
                        if (!addr_ok) begin
                            addr_err_q <= 1'b1;
                        end
                    end
                    if (layer_ack_i) begin
                        res_data0_q <= layer_out0_i;
                        res_data1_q <= layer_out1_i;
                        res_valid_q <= 1'b1;
                        req_q       <= 1'b0;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign load_ready_o = (state_q == LOAD);
    assign req_o        = req_q;
    assign rd_ack_o     = rd_ack_q;
    assign rd_data_o    = rd_data_q;
    assign res_valid_o  = res_valid_q;
    assign res_data0_o  = res_data0_q;
    assign res_data1_o  = res_data1_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_layer_input_server.sv
// tb/tb_layer_input_server.sv - bench for layer_input_server
module tb_layer_input_server;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              req;
    logic              rd_trig;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              layer_ack;
    logic [DATA_W-1:0] layer_out0;
    logic [DATA_W-1:0] layer_out1;
    logic              res_valid;
    logic [DATA_W-1:0] res_data0;
    logic [DATA_W-1:0] res_data1;
    logic              res_ready;
    logic              addr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_input_server #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_valid_i(load_valid), .load_data_i(load_data), .load_ready_o(load_ready),
        .req_o(req),
        .rd_trig_i(rd_trig), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ack_o(rd_ack),
        .layer_ack_i(layer_ack), .layer_out0_i(layer_out0), .layer_out1_i(layer_out1),
        .res_valid_o(res_valid), .res_data0_o(res_data0), .res_data1_o(res_data1),
        .res_ready_i(res_ready), .addr_err_o(addr_err)
    );

    typedef struct {
        logic              lv;
        logic [DATA_W-1:0] ld;
        logic              trig;
        logic [ADDR_W-1:0] ad;
        logic              lack;
        logic [DATA_W-1:0] o0;
        logic [DATA_W-1:0] o1;
        logic              rr;
        logic              e_lr;
        logic              e_req;
        logic              e_ack;
        logic [DATA_W-1:0] e_rd;
        logic              e_rv;
        logic [DATA_W-1:0] e_r0;
        logic [DATA_W-1:0] e_r1;
    } vec_t;

    vec_t tbl [25];

    // Reference model state: phase 0=loading, 1=serving reads, 2=holding results
    int                m_phase;
    logic [DATA_W-1:0] m_fill [$];
    logic [DATA_W-1:0] m_words [DEPTH];
    logic              m_req, m_ack, m_rv, m_err;
    logic [DATA_W-1:0] m_rd, m_r0, m_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic lr, input logic rq, input logic ak,
                            input logic [DATA_W-1:0] rd, input logic rv,
                            input logic [DATA_W-1:0] r0, input logic [DATA_W-1:0] r1,
                            input logic er);
        chk({tag, " load_ready"}, load_ready, lr);
        chk({tag, " req"}, req, rq);
        chk({tag, " rd_ack"}, rd_ack, ak);
        chk({tag, " rd_data"}, rd_data, rd);
        chk({tag, " res_valid"}, res_valid, rv);
        chk({tag, " res_data0"}, res_data0, r0);
        chk({tag, " res_data1"}, res_data1, r1);
        chk({tag, " addr_err"}, addr_err, er);
    endtask

    task automatic idle_inputs();
        load_valid = 0; load_data = '0; rd_trig = 0; rd_addr = '0;
        layer_ack = 0; layer_out0 = '0; layer_out1 = '0; res_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_phase = 0;
        m_fill.delete();
        for (int i = 0; i < DEPTH; i++) m_words[i] = '0;
        m_req = 0; m_ack = 0; m_rv = 0; m_err = 0;
        m_rd = '0; m_r0 = '0; m_r1 = '0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        m_ack = 0;
        if (m_phase == 0) begin
            if (load_valid) begin
                m_fill.push_back(load_data);
                if (m_fill.size() == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) m_words[i] = m_fill[i];
                    m_fill.delete();
                    m_req = 1;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (rd_trig) begin
                m_ack = 1;
                if (int'(rd_addr) < DEPTH) m_rd = m_words[int'(rd_addr)];
                else begin
                    m_rd = '0;
                    m_err = 1;
                end
            end
            if (layer_ack) begin
                m_r0 = layer_out0; m_r1 = layer_out1;
                m_rv = 1; m_req = 0; m_phase = 2;
            end
        end else begin
            if (res_ready) begin
                m_rv = 0;
                m_phase = 0;
            end
        end
    endtask

    vec_t idle_v, trig1_v;

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 chk_outs("reset", 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
        do_reset();

        tbl[0] = '{1, 8'd16, 0, 0, 0, 0, 0, 0,  1, 0, 0, 8'h00, 0, 8'h00, 8'h00};
        tbl[1] = '{1, 8'hE0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 8'h00, 0, 8'h00, 8'h00};
        tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 1, 1, 8'd16, 0, 8'h00, 8'h00};
        tbl[3] = '{0, 8'h00, 1, 1, 0, 0, 0, 0,  0, 1, 1, 8'hE0, 0, 8'h00, 8'h00};
        idle_v  = '{0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 1, 0, 8'hE0, 0, 8'h00, 8'h00};
        trig1_v = '{0, 8'h00, 1, 1, 0, 0, 0, 0,  0, 1, 1, 8'hE0, 0, 8'h00, 8'h00};
        for (int i = 4; i <= 14; i++) tbl[i] = (i >= 5 && (i - 5) % 3 == 0) ? trig1_v : idle_v;
        tbl[15] = '{0, 8'h00, 1, 0, 1, 8'd5, 8'hFD, 0,  0, 0, 1, 8'd16, 1, 8'd5, 8'hFD};
        for (int i = 16; i <= 19; i++)
            tbl[i] = '{1, 8'd99, 1, 1, 1, 8'd77, 8'hB3, 0,  0, 0, 0, 8'd16, 1, 8'd5, 8'hFD};
        tbl[20] = '{0, 8'h00, 0, 0, 0, 0, 0, 1,  1, 0, 0, 8'd16, 0, 8'd5, 8'hFD};
        tbl[21] = '{1, 8'd7, 0, 0, 0, 0, 0, 0,  1, 0, 0, 8'd16, 0, 8'd5, 8'hFD};
        tbl[22] = '{1, 8'd8, 0, 0, 0, 0, 0, 0,  0, 1, 0, 8'd16, 0, 8'd5, 8'hFD};
        tbl[23] = '{0, 8'h00, 1, 0, 0, 0, 0, 0,  0, 1, 1, 8'd7, 0, 8'd5, 8'hFD};
        tbl[24] = '{0, 8'h00, 1, 1, 0, 0, 0, 0,  0, 1, 1, 8'd8, 0, 8'd5, 8'hFD};

        for (int i = 0; i < 25; i++) begin
            load_valid = tbl[i].lv;   load_data  = tbl[i].ld;
            rd_trig    = tbl[i].trig; rd_addr    = tbl[i].ad;
            layer_ack  = tbl[i].lack; layer_out0 = tbl[i].o0; layer_out1 = tbl[i].o1;
            res_ready  = tbl[i].rr;
            @(posedge clk);
            #1 chk_outs($sformatf("row%0d", i), tbl[i].e_lr, tbl[i].e_req, tbl[i].e_ack,
                        tbl[i].e_rd, tbl[i].e_rv, tbl[i].e_r0, tbl[i].e_r1, 1'b0);
        end

        // Asynchronous reset mid-run, away from any clock edge
        idle_inputs();
        rst_n = 1'b0;
        #3 chk_outs("async_rst", 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
        rst_n = 1'b1;
        rd_trig = 1; rd_addr = '0;
        @(posedge clk);
        #1 chk_outs("read_in_load", 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = DATA_W'($urandom);
            rd_trig    = 1'($urandom_range(0, 1));
            rd_addr    = ADDR_W'($urandom);
            layer_ack  = ($urandom_range(0, 7) == 0);
            layer_out0 = DATA_W'($urandom);
            layer_out1 = DATA_W'($urandom);
            res_ready  = ($urandom_range(0, 2) == 0);
            model_step();
            @(posedge clk);
            #1 chk_outs($sformatf("rand%0d", c), (m_phase == 0), m_req, m_ack, m_rd,
                        m_rv, m_r0, m_r1, m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
